// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core bus controller: FSM states, transaction
// owners, cache-line geometry and line-address alignment.
package core_bus_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;

  typedef enum logic [1:0] {IDLE, LINE, SINGLE, DONE} state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC, OWN_BUS} owner_e;

  // Cache lines are 16 bytes, so the base address drops the low nibble.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & 32'hFFFF_FFF0;
  endfunction

endpackage

// File: rtl/core_bus_line_buf.sv
// Read-line assembly buffer: inserts one 32-bit word per beat and exposes the
// line including the word being written this cycle.
module core_bus_line_buf
  import core_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [1:0]           idx,
  input  logic [31:0]          word,
  output logic [LINE_BITS-1:0] line_next
);

  logic [LINE_BITS-1:0] line_q;

  // The look-ahead view lets the final beat land in the output line on the same edge.
  always_comb begin
    line_next = line_q;
    if (wr_en) line_next[{idx, 5'b0} +: 32] = word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) line_q <= '0;
    else        line_q <= line_next;
  end

endmodule

// File: rtl/core_bus_ctrl.sv
// Bus controller arbitrating Dcache, uncached and Icache requests onto a single
// external master port; one transaction at a time, line transfers as 4 beats.
module core_bus_ctrl
  import core_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ic_req_i,
  input  logic [31:0]          ic_addr_i,
  output logic                 bc_Icache_ready_o,
  output logic [LINE_BITS-1:0] bc_Icache_line_o,
  input  logic                 dc_req_i,
  input  logic                 dc_we_i,
  input  logic [31:0]          dc_addr_i,
  input  logic [LINE_BITS-1:0] dc_wline_i,
  output logic                 bc_Dcache_ready_o,
  output logic [LINE_BITS-1:0] bc_Dcache_line_o,
  input  logic                 bus_req_i,
  input  logic                 bus_we_i,
  input  logic [31:0]          bus_addr_i,
  input  logic [31:0]          bus_wdata_i,
  input  logic [3:0]           bus_be_i,
  output logic                 bc_bus_ready_o,
  output logic [31:0]          bc_bus_rdata_o,
  output logic                 m_req_o,
  output logic                 m_we_o,
  output logic [31:0]          m_addr_o,
  output logic [31:0]          m_wdata_o,
  output logic [3:0]           m_be_o,
  input  logic                 m_ack_i,
  input  logic [31:0]          m_rdata_i
);

  state_e               state;
  owner_e               owner;
  logic                 we_q;
  logic [LINE_BITS-1:0] wline_q;
  logic [1:0]           beat;
  logic [1:0]           beat_nx;
  logic                 ack;
  logic                 buf_wr;
  logic [LINE_BITS-1:0] line_next;

  // An ack only counts while a beat is actually on the bus.
  assign ack     = m_req_o && m_ack_i;
  assign beat_nx = beat + 2'd1;
  assign buf_wr  = ack && (state == LINE) && !we_q;

  core_bus_line_buf u_line_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (buf_wr),
    .idx       (beat),
    .word      (m_rdata_i),
    .line_next (line_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      owner             <= OWN_NONE;
      we_q              <= 1'b0;
      wline_q           <= '0;
      beat              <= 2'd0;
      m_req_o           <= 1'b0;
      m_we_o            <= 1'b0;
      m_addr_o          <= '0;
      m_wdata_o         <= '0;
      m_be_o            <= '0;
      bc_Icache_ready_o <= 1'b0;
      bc_Dcache_ready_o <= 1'b0;
      bc_bus_ready_o    <= 1'b0;
      bc_Icache_line_o  <= '0;
      bc_Dcache_line_o  <= '0;
      bc_bus_rdata_o    <= '0;
    end else begin
      bc_Icache_ready_o <= 1'b0;
      bc_Dcache_ready_o <= 1'b0;
      bc_bus_ready_o    <= 1'b0;
      case (state)
        IDLE: begin
          beat <= 2'd0;
          if (dc_req_i) begin
            owner     <= OWN_DC;
            we_q      <= dc_we_i;
            wline_q   <= dc_wline_i;
            m_req_o   <= 1'b1;
            m_we_o    <= dc_we_i;
            m_addr_o  <= line_base(dc_addr_i);
            m_wdata_o <= dc_we_i ? dc_wline_i[31:0] : 32'd0;
            m_be_o    <= 4'hF;
            state     <= LINE;
          end else if (bus_req_i) begin
            owner     <= OWN_BUS;
            we_q      <= bus_we_i;
            m_req_o   <= 1'b1;
            m_we_o    <= bus_we_i;
            m_addr_o  <= bus_addr_i;
            m_wdata_o <= bus_wdata_i;
            m_be_o    <= bus_be_i;
            state     <= SINGLE;
          end else if (ic_req_i) begin
            owner     <= OWN_IC;
            we_q      <= 1'b0;
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_addr_o  <= line_base(ic_addr_i);
            m_wdata_o <= 32'd0;
            m_be_o    <= 4'hF;
            state     <= LINE;
          end
        end
        LINE: begin
          if (ack) begin
            beat <= beat_nx;
            if (beat == 2'd3) begin
              m_req_o <= 1'b0;
              state   <= DONE;
              if (owner == OWN_IC) begin
                bc_Icache_ready_o <= 1'b1;
                bc_Icache_line_o  <= line_next;
              end else begin
                bc_Dcache_ready_o <= 1'b1;
                if (!we_q) bc_Dcache_line_o <= line_next;
              end
            end else begin
              m_addr_o  <= m_addr_o + 32'd4;
              m_wdata_o <= we_q ? wline_q[{beat_nx, 5'b0} +: 32] : 32'd0;
            end
          end
        end
        SINGLE: begin
          if (ack) begin
            m_req_o        <= 1'b0;
            bc_bus_ready_o <= 1'b1;
            if (!we_q) bc_bus_rdata_o <= m_rdata_i;
            state          <= DONE;
          end
        end
        DONE: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_ctrl.sv
// Directed self-checking bench for core_bus_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_core_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req_i, dc_req_i, dc_we_i, bus_req_i, bus_we_i, m_ack_i;
  logic [31:0]  ic_addr_i, dc_addr_i, bus_addr_i, bus_wdata_i, m_rdata_i;
  logic [127:0] dc_wline_i;
  logic [3:0]   bus_be_i;
  logic         bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o;
  logic [127:0] bc_Icache_line_o, bc_Dcache_line_o;
  logic [31:0]  bc_bus_rdata_o;
  logic         m_req_o, m_we_o;
  logic [31:0]  m_addr_o, m_wdata_o;
  logic [3:0]   m_be_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  core_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
    .bc_Icache_ready_o(bc_Icache_ready_o), .bc_Icache_line_o(bc_Icache_line_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wline_i(dc_wline_i),
    .bc_Dcache_ready_o(bc_Dcache_ready_o), .bc_Dcache_line_o(bc_Dcache_line_o),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
    .bus_wdata_i(bus_wdata_i), .bus_be_i(bus_be_i),
    .bc_bus_ready_o(bc_bus_ready_o), .bc_bus_rdata_o(bc_bus_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i)
  );

  task automatic clear_inputs();
    ic_req_i = 0; dc_req_i = 0; dc_we_i = 0; bus_req_i = 0; bus_we_i = 0; m_ack_i = 0;
    ic_addr_i = 0; dc_addr_i = 0; bus_addr_i = 0; bus_wdata_i = 0; m_rdata_i = 0;
    dc_wline_i = 0; bus_be_i = 0;
  endtask

  task automatic test_reset();
    logic [360:0] obs;
    rst_n = 0;
    ic_req_i = 1; dc_req_i = 1; bus_req_i = 1; m_ack_i = 1; m_rdata_i = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    obs = {bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o, m_we_o, m_addr_o,
           m_wdata_o, m_be_o, bc_Icache_line_o, bc_Dcache_line_o, bc_bus_rdata_o};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    clear_inputs();
    rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({m_req_o, bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %b expected 0000",
               {m_req_o, bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o});
    end
  endtask

  task automatic test_ic_refill();
    logic [127:0] exp_line;
    logic [38:0]  obs, exp;
    exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    // Ack is already high while m_req_o is low: it must be ignored.
    ic_req_i = 1; ic_addr_i = 32'h0000_1238; m_ack_i = 1;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      obs = {m_req_o, m_we_o, m_addr_o, m_be_o, bc_Icache_ready_o};
      exp = {1'b1, 1'b0, 32'h1230 + 32'(4 * n), 4'hF, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL ic_beat%0d: got %h expected %h", n, obs, exp);
      end
      m_rdata_i = 32'hA0 + 32'(n);
      @(negedge clk);
    end
    vectors++;
    if ({bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL ic_done: got %b expected 1000",
               {bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o});
    end
    vectors++;
    if (bc_Icache_line_o !== exp_line) begin
      miscompares++;
      $display("[TB] FAIL ic_line: got %h expected %h", bc_Icache_line_o, exp_line);
    end
    ic_req_i = 0; m_ack_i = 0;
    @(negedge clk);
    vectors++;
    if ({bc_Icache_ready_o, bc_Icache_line_o} !== {1'b0, exp_line}) begin
      miscompares++;
      $display("[TB] FAIL ic_hold: got %h expected %h", {bc_Icache_ready_o, bc_Icache_line_o},
               {1'b0, exp_line});
    end
  endtask

  task automatic test_priority();
    logic [127:0] dline, iline, aline;
    dline = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    iline = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    aline = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    ic_req_i = 1; ic_addr_i = 32'h0000_3004;
    dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h0000_2000; m_ack_i = 1;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 32'h2000 + 32'(4 * n)}) begin
        miscompares++;
        $display("[TB] FAIL prio_dc_beat%0d: got %h expected %h", n, {m_req_o, m_we_o, m_addr_o},
                 {1'b1, 1'b0, 32'h2000 + 32'(4 * n)});
      end
      m_rdata_i = 32'hB0 + 32'(n);
      @(negedge clk);
    end
    vectors++;
    if ({bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o} !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL prio_dc_done: got %b expected 0100",
               {bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o});
    end
    vectors++;
    if ({bc_Dcache_line_o, bc_Icache_line_o} !== {dline, aline}) begin
      miscompares++;
      $display("[TB] FAIL prio_lines: got %h expected %h", {bc_Dcache_line_o, bc_Icache_line_o},
               {dline, aline});
    end
    dc_req_i = 0;
    @(negedge clk);
    vectors++;
    if ({m_req_o, bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL prio_idle_gap: got %b expected 0000",
               {m_req_o, bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o});
    end
    @(negedge clk);
    vectors++;
    if ({m_req_o, m_addr_o} !== {1'b1, 32'h0000_3000}) begin
      miscompares++;
      $display("[TB] FAIL prio_ic_grant: got %h expected %h", {m_req_o, m_addr_o},
               {1'b1, 32'h0000_3000});
    end
    for (int n = 0; n < 4; n++) begin
      m_rdata_i = 32'hC0 + 32'(n);
      @(negedge clk);
    end
    vectors++;
    if ({bc_Icache_ready_o, bc_Dcache_ready_o, bc_Icache_line_o} !== {2'b10, iline}) begin
      miscompares++;
      $display("[TB] FAIL prio_ic_done: got %h expected %h",
               {bc_Icache_ready_o, bc_Dcache_ready_o, bc_Icache_line_o}, {2'b10, iline});
    end
    ic_req_i = 0; m_ack_i = 0;
    @(negedge clk);
  endtask

  task automatic test_uncached();
    logic [69:0] obs, exp;
    bus_req_i = 1; bus_we_i = 1; bus_addr_i = 32'h4000_0004; bus_wdata_i = 32'h55;
    bus_be_i = 4'b0011; m_ack_i = 0;
    @(negedge clk);
    // Later changes on the requester side must not leak into the latched beat.
    bus_addr_i = 32'h0; bus_wdata_i = 32'hFFFF_FFFF; bus_be_i = 4'hF;
    exp = {1'b1, 1'b1, 32'h4000_0004, 32'h55, 4'b0011};
    for (int c = 0; c < 4; c++) begin
      obs = {m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o};
      vectors++;
      if (obs !== exp || bc_bus_ready_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL unc_wr_cycle%0d: got %h rdy %b expected %h rdy 0", c, obs,
                 bc_bus_ready_o, exp);
      end
      m_ack_i = (c == 3);
      @(negedge clk);
    end
    vectors++;
    if ({bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL unc_wr_done: got %b expected 0010",
               {bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o});
    end
    bus_req_i = 0; m_ack_i = 0;
    @(negedge clk);
    vectors++;
    if (bc_bus_ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unc_wr_single_pulse: got %b expected 0", bc_bus_ready_o);
    end
    bus_req_i = 1; bus_we_i = 0; bus_addr_i = 32'h4000_0010; bus_be_i = 4'hF;
    m_ack_i = 1; m_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 32'h4000_0010}) begin
      miscompares++;
      $display("[TB] FAIL unc_rd_beat: got %h expected %h", {m_req_o, m_we_o, m_addr_o},
               {1'b1, 1'b0, 32'h4000_0010});
    end
    @(negedge clk);
    vectors++;
    if ({bc_bus_ready_o, m_req_o, bc_bus_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL unc_rd_done: got %h expected %h", {bc_bus_ready_o, m_req_o, bc_bus_rdata_o},
               {2'b10, 32'hDEAD_BEEF});
    end
    bus_req_i = 0; m_ack_i = 0; m_rdata_i = 32'h0;
    @(negedge clk);
    vectors++;
    if ({bc_bus_ready_o, bc_bus_rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL unc_rd_hold: got %h expected %h", {bc_bus_ready_o, bc_bus_rdata_o},
               {1'b0, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_dc_writeback();
    logic [127:0] wline;
    logic [69:0]  obs, exp;
    wline = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    dc_req_i = 1; dc_we_i = 1; dc_addr_i = 32'h0000_5004; dc_wline_i = wline; m_ack_i = 0;
    @(negedge clk);
    dc_wline_i = '1;
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 3; w++) begin
        obs = {m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o};
        exp = {1'b1, 1'b1, 32'h5000 + 32'(4 * n), wline[32 * n +: 32], 4'hF};
        vectors++;
        if (obs !== exp || bc_Dcache_ready_o !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL wb_beat%0d_wait%0d: got %h rdy %b expected %h rdy 0", n, w, obs,
                   bc_Dcache_ready_o, exp);
        end
        m_ack_i = (w == 2);
        @(negedge clk);
      end
    end
    vectors++;
    if ({bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o} !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL wb_done: got %b expected 0100",
               {bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o});
    end
    dc_req_i = 0; m_ack_i = 0;
    @(negedge clk);
    vectors++;
    if ({bc_Dcache_ready_o, m_req_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL wb_single_pulse: got %b expected 00", {bc_Dcache_ready_o, m_req_o});
    end
  endtask

  task automatic test_drop_and_reset();
    logic [127:0] dline;
    logic [360:0] obs;
    dline = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    ic_req_i = 1; ic_addr_i = 32'h0000_6000; m_ack_i = 1;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if ({m_req_o, m_addr_o} !== {1'b1, 32'h6000 + 32'(4 * n)}) begin
        miscompares++;
        $display("[TB] FAIL drop_beat%0d: got %h expected %h", n, {m_req_o, m_addr_o},
                 {1'b1, 32'h6000 + 32'(4 * n)});
      end
      m_rdata_i = 32'hD0 + 32'(n);
      if (n == 1) ic_req_i = 0;
      @(negedge clk);
    end
    vectors++;
    if ({bc_Icache_ready_o, bc_Icache_line_o} !== {1'b1, dline}) begin
      miscompares++;
      $display("[TB] FAIL drop_done: got %h expected %h", {bc_Icache_ready_o, bc_Icache_line_o},
               {1'b1, dline});
    end
    @(negedge clk);
    vectors++;
    if ({bc_Icache_ready_o, m_req_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL drop_no_regrant: got %b expected 00", {bc_Icache_ready_o, m_req_o});
    end
    ic_req_i = 1; ic_addr_i = 32'h0000_7000;
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_req_o, m_addr_o} !== {1'b1, 32'h0000_7008}) begin
      miscompares++;
      $display("[TB] FAIL rst_beat2: got %h expected %h", {m_req_o, m_addr_o}, {1'b1, 32'h0000_7008});
    end
    rst_n = 0;
    @(negedge clk);
    obs = {bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o, m_we_o, m_addr_o,
           m_wdata_o, m_be_o, bc_Icache_line_o, bc_Dcache_line_o, bc_bus_rdata_o};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_abandon: got %h expected 0", obs);
    end
    rst_n = 1; ic_req_i = 0; m_ack_i = 0;
    @(negedge clk);
    vectors++;
    if ({bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL rst_no_ready: got %b expected 0000",
               {bc_Icache_ready_o, bc_Dcache_ready_o, bc_bus_ready_o, m_req_o});
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_ic_refill();
    test_priority();
    test_uncached();
    test_dc_writeback();
    test_drop_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
